// File: rtl/map_gap_controller.sv
// Animates the four doorway gaps of the cross-shaped arena map and publishes
// the live gap edge coordinates for the renderer.
module map_gap_controller #(
  parameter int STEP_DIV   = 2500000,
  parameter int HOLD_TICKS = 80,
  parameter int MAX_HALF   = 6,
  parameter int LEFT_C     = 24,
  parameter int RIGHT_C    = 72,
  parameter int TOP_C      = 16,
  parameter int BOT_C      = 48
) (
  input  logic       basys_clk,
  input  logic       reset,
  input  logic [3:0] open_req,
  input  logic [3:0] force_close,
  output logic [6:0] left_lo,
  output logic [6:0] left_hi,
  output logic [6:0] right_lo,
  output logic [6:0] right_hi,
  output logic [6:0] top_lo,
  output logic [6:0] top_hi,
  output logic [6:0] bot_lo,
  output logic [6:0] bot_hi,
  output logic [3:0] gap_open,
  output logic [3:0] gap_busy
);

  localparam int         CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [3:0] MAX_H     = 4'(MAX_HALF);
  localparam logic [6:0] HOLD_LAST = 7'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } gap_state_t;

  logic [CNT_W-1:0] tick_cnt_r;
  logic             tick_s;
  gap_state_t       state_r [4];
  gap_state_t       state_s [4];
  logic [3:0]       half_r  [4];
  logic [3:0]       half_s  [4];
  logic [6:0]       hold_r  [4];
  logic [6:0]       hold_s  [4];
  logic [6:0]       lo_r    [4];
  logic [6:0]       hi_r    [4];
  logic [3:0]       open_r;
  logic [3:0]       busy_r;

  function automatic logic [6:0] centre(input int g);
    case (g)
      0:       centre = 7'(LEFT_C);
      1:       centre = 7'(RIGHT_C);
      2:       centre = 7'(TOP_C);
      3:       centre = 7'(BOT_C);
      default: centre = 7'd0;
    endcase
  endfunction

  assign tick_s = (tick_cnt_r == CNT_W'(STEP_DIV - 1));

  // Free-running step tick divider shared by all gaps.
  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + CNT_W'(1);
    end
  end

  // Per-gap next state, half-width and hold count.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      state_s[g] = state_r[g];
      half_s[g]  = half_r[g];
      hold_s[g]  = hold_r[g];
      case (state_r[g])
        CLOSED: begin
          if (open_req[g]) begin
            state_s[g] = OPENING;
          end else begin
            state_s[g] = CLOSED;
          end
        end
        OPENING: begin
          if (force_close[g]) begin
            state_s[g] = CLOSING;
          end else if (tick_s && (half_r[g] >= MAX_H - 4'd1)) begin
            half_s[g]  = MAX_H;
            state_s[g] = OPEN;
            hold_s[g]  = 7'd0;
          end else if (tick_s) begin
            half_s[g] = half_r[g] + 4'd1;
          end else begin
            half_s[g] = half_r[g];
          end
        end
        OPEN: begin
          // A restart request beats a coincident tick.
          if (force_close[g]) begin
            state_s[g] = CLOSING;
          end else if (open_req[g]) begin
            hold_s[g] = 7'd0;
          end else if (tick_s && (hold_r[g] == HOLD_LAST)) begin
            state_s[g] = CLOSING;
          end else if (tick_s) begin
            hold_s[g] = hold_r[g] + 7'd1;
          end else begin
            hold_s[g] = hold_r[g];
          end
        end
        CLOSING: begin
          if (!force_close[g] && open_req[g]) begin
            state_s[g] = OPENING;
          end else if (tick_s && (half_r[g] <= 4'd1)) begin
            half_s[g]  = 4'd0;
            state_s[g] = CLOSED;
          end else if (tick_s) begin
            half_s[g] = half_r[g] - 4'd1;
          end else begin
            half_s[g] = half_r[g];
          end
        end
        default: begin
          state_s[g] = CLOSED;
          half_s[g]  = 4'd0;
          hold_s[g]  = 7'd0;
        end
      endcase
    end
  end

  // State registers plus edge/status outputs registered from the next state.
  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < 4; g++) begin
        state_r[g] <= CLOSED;
        half_r[g]  <= 4'd0;
        hold_r[g]  <= 7'd0;
        lo_r[g]    <= centre(g);
        hi_r[g]    <= centre(g);
      end
      open_r <= 4'd0;
      busy_r <= 4'd0;
    end else begin
      for (int g = 0; g < 4; g++) begin
        state_r[g] <= state_s[g];
        half_r[g]  <= half_s[g];
        hold_r[g]  <= hold_s[g];
        lo_r[g]    <= centre(g) - {3'b000, half_s[g]};
        hi_r[g]    <= centre(g) + {3'b000, half_s[g]};
        open_r[g]  <= (state_s[g] == OPEN);
        busy_r[g]  <= (state_s[g] != CLOSED);
      end
    end
  end

  assign left_lo  = lo_r[0];
  assign left_hi  = hi_r[0];
  assign right_lo = lo_r[1];
  assign right_hi = hi_r[1];
  assign top_lo   = lo_r[2];
  assign top_hi   = hi_r[2];
  assign bot_lo   = lo_r[3];
  assign bot_hi   = hi_r[3];
  assign gap_open = open_r;
  assign gap_busy = busy_r;

endmodule

// File: tb/tb_map_gap_controller.sv
// Table-driven bench for map_gap_controller with a small expectation queue.
module tb_map_gap_controller;

  localparam int STEP_DIV   = 4;
  localparam int HOLD_TICKS = 2;
  localparam int MAX_HALF   = 3;
  localparam int LEFT_C     = 24;
  localparam int RIGHT_C    = 72;
  localparam int TOP_C      = 16;
  localparam int BOT_C      = 48;

  logic       basys_clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] open_req = 4'd0;
  logic [3:0] force_close = 4'd0;
  logic [6:0] left_lo, left_hi, right_lo, right_hi;
  logic [6:0] top_lo, top_hi, bot_lo, bot_hi;
  logic [3:0] gap_open, gap_busy;

  map_gap_controller #(
    .STEP_DIV(STEP_DIV), .HOLD_TICKS(HOLD_TICKS), .MAX_HALF(MAX_HALF),
    .LEFT_C(LEFT_C), .RIGHT_C(RIGHT_C), .TOP_C(TOP_C), .BOT_C(BOT_C)
  ) dut (
    .basys_clk(basys_clk), .reset(reset),
    .open_req(open_req), .force_close(force_close),
    .left_lo(left_lo), .left_hi(left_hi),
    .right_lo(right_lo), .right_hi(right_hi),
    .top_lo(top_lo), .top_hi(top_hi),
    .bot_lo(bot_lo), .bot_hi(bot_hi),
    .gap_open(gap_open), .gap_busy(gap_busy)
  );

  always #5 basys_clk = ~basys_clk;

  // h packs the expected half-widths as {bot, top, right, left}, one nibble each.
  typedef struct {
    logic [3:0]  op_req;
    logic [3:0]  fc;
    int          ncyc;
    logic        mid_reset;
    logic [15:0] h;
    logic [3:0]  gopen;
    logic [3:0]  gbusy;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] h;
    logic [3:0]  gopen;
    logic [3:0]  gbusy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [6:0] ctr(input int g);
    case (g)
      0:       ctr = 7'(LEFT_C);
      1:       ctr = 7'(RIGHT_C);
      2:       ctr = 7'(TOP_C);
      default: ctr = 7'(BOT_C);
    endcase
  endfunction

  task automatic add(input logic [3:0] o, input logic [3:0] f, input int n,
                     input logic r, input logic [15:0] h,
                     input logic [3:0] op, input logic [3:0] bz);
    vec_t v;
    v.op_req = o; v.fc = f; v.ncyc = n; v.mid_reset = r;
    v.h = h; v.gopen = op; v.gbusy = bz;
    tbl.push_back(v);
  endtask

  task automatic check_outputs(input exp_t e);
    logic [6:0] act_lo [4];
    logic [6:0] act_hi [4];
    logic [6:0] elo, ehi;
    act_lo[0] = left_lo;  act_hi[0] = left_hi;
    act_lo[1] = right_lo; act_hi[1] = right_hi;
    act_lo[2] = top_lo;   act_hi[2] = top_hi;
    act_lo[3] = bot_lo;   act_hi[3] = bot_hi;
    vectors++;
    for (int g = 0; g < 4; g++) begin
      elo = ctr(g) - {3'b000, e.h[g*4 +: 4]};
      ehi = ctr(g) + {3'b000, e.h[g*4 +: 4]};
      if (act_lo[g] !== elo) begin
        miscompares++;
        $display("FAIL vec%0d lo[%0d]: got %0d expected %0d", e.idx, g, act_lo[g], elo);
      end
      if (act_hi[g] !== ehi) begin
        miscompares++;
        $display("FAIL vec%0d hi[%0d]: got %0d expected %0d", e.idx, g, act_hi[g], ehi);
      end
    end
    if (gap_open !== e.gopen) begin
      miscompares++;
      $display("FAIL vec%0d gap_open: got %b expected %b", e.idx, gap_open, e.gopen);
    end
    if (gap_busy !== e.gbusy) begin
      miscompares++;
      $display("FAIL vec%0d gap_busy: got %b expected %b", e.idx, gap_busy, e.gbusy);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    e.idx = idx; e.h = v.h; e.gopen = v.gopen; e.gbusy = v.gbusy;
    if (v.mid_reset) begin
      sb.push_back(e);
      #2 reset = 1'b1;
      #1 check_outputs(sb.pop_front());
      repeat (2) @(posedge basys_clk);
      @(negedge basys_clk);
      reset = 1'b0;
    end else begin
      open_req = v.op_req;
      force_close = v.fc;
      sb.push_back(e);
      for (int c = 0; c < v.ncyc; c++) begin
        @(posedge basys_clk);
        #1;
        open_req = 4'd0;
        force_close = 4'd0;
      end
      check_outputs(sb.pop_front());
    end
  endtask

  initial begin
    exp_t e0;
    // Edge numbers in comments count posedges since reset release; ticks land on multiples of 4.
    // Left gap: open, hold, close.
    add(4'h1, 4'h0, 1, 1'b0, 16'h0000, 4'h0, 4'h1); // 1
    add(4'h0, 4'h0, 2, 1'b0, 16'h0000, 4'h0, 4'h1); // 3
    add(4'h0, 4'h0, 1, 1'b0, 16'h0001, 4'h0, 4'h1); // 4
    add(4'h0, 4'h0, 4, 1'b0, 16'h0002, 4'h0, 4'h1); // 8
    add(4'h0, 4'h0, 4, 1'b0, 16'h0003, 4'h1, 4'h1); // 12
    add(4'h0, 4'h0, 4, 1'b0, 16'h0003, 4'h1, 4'h1); // 16
    add(4'h0, 4'h0, 4, 1'b0, 16'h0003, 4'h0, 4'h1); // 20
    add(4'h0, 4'h0, 4, 1'b0, 16'h0002, 4'h0, 4'h1); // 24
    add(4'h0, 4'h0, 4, 1'b0, 16'h0001, 4'h0, 4'h1); // 28
    add(4'h0, 4'h0, 4, 1'b0, 16'h0000, 4'h0, 4'h0); // 32
    // Extend while open, then reopen while closing.
    add(4'h1, 4'h0, 1, 1'b0, 16'h0000, 4'h0, 4'h1); // 33
    add(4'h0, 4'h0, 3, 1'b0, 16'h0001, 4'h0, 4'h1); // 36
    add(4'h0, 4'h0, 4, 1'b0, 16'h0002, 4'h0, 4'h1); // 40
    add(4'h0, 4'h0, 4, 1'b0, 16'h0003, 4'h1, 4'h1); // 44
    add(4'h0, 4'h0, 4, 1'b0, 16'h0003, 4'h1, 4'h1); // 48
    add(4'h1, 4'h0, 1, 1'b0, 16'h0003, 4'h1, 4'h1); // 49
    add(4'h0, 4'h0, 3, 1'b0, 16'h0003, 4'h1, 4'h1); // 52
    add(4'h0, 4'h0, 4, 1'b0, 16'h0003, 4'h0, 4'h1); // 56
    add(4'h0, 4'h0, 4, 1'b0, 16'h0002, 4'h0, 4'h1); // 60
    add(4'h1, 4'h0, 1, 1'b0, 16'h0002, 4'h0, 4'h1); // 61
    add(4'h0, 4'h0, 3, 1'b0, 16'h0003, 4'h1, 4'h1); // 64
    add(4'h0, 4'h0, 20, 1'b0, 16'h0000, 4'h0, 4'h0); // 84
    // All open, then open-all with force_close on gap 0 at a tick.
    add(4'hF, 4'h0, 1, 1'b0, 16'h0000, 4'h0, 4'hF); // 85
    add(4'h0, 4'h0, 3, 1'b0, 16'h1111, 4'h0, 4'hF); // 88
    add(4'h0, 4'h0, 4, 1'b0, 16'h2222, 4'h0, 4'hF); // 92
    add(4'h0, 4'h0, 4, 1'b0, 16'h3333, 4'hF, 4'hF); // 96
    add(4'h0, 4'h0, 3, 1'b0, 16'h3333, 4'hF, 4'hF); // 99
    add(4'hF, 4'h1, 1, 1'b0, 16'h3333, 4'hE, 4'hF); // 100
    add(4'h0, 4'h0, 4, 1'b0, 16'h3332, 4'hE, 4'hF); // 104
    add(4'h0, 4'h0, 4, 1'b0, 16'h3331, 4'h0, 4'hF); // 108
    add(4'h0, 4'h0, 4, 1'b0, 16'h2220, 4'h0, 4'hE); // 112
    add(4'h0, 4'h0, 4, 1'b0, 16'h1110, 4'h0, 4'hE); // 116
    add(4'h0, 4'h0, 4, 1'b0, 16'h0000, 4'h0, 4'h0); // 120
    add(4'h0, 4'hF, 1, 1'b0, 16'h0000, 4'h0, 4'h0); // 121
    add(4'h0, 4'h0, 3, 1'b0, 16'h0000, 4'h0, 4'h0); // 124
    // Top and bottom staggered by one tick.
    add(4'h4, 4'h0, 1, 1'b0, 16'h0000, 4'h0, 4'h4); // 125
    add(4'h0, 4'h0, 3, 1'b0, 16'h0100, 4'h0, 4'h4); // 128
    add(4'h8, 4'h0, 1, 1'b0, 16'h0100, 4'h0, 4'hC); // 129
    add(4'h0, 4'h0, 3, 1'b0, 16'h1200, 4'h0, 4'hC); // 132
    add(4'h0, 4'h0, 4, 1'b0, 16'h2300, 4'h4, 4'hC); // 136
    add(4'h0, 4'h0, 4, 1'b0, 16'h3300, 4'hC, 4'hC); // 140
    add(4'h0, 4'h0, 4, 1'b0, 16'h3300, 4'h8, 4'hC); // 144
    add(4'h0, 4'h0, 4, 1'b0, 16'h3200, 4'h0, 4'hC); // 148
    add(4'h0, 4'h0, 12, 1'b0, 16'h0000, 4'h0, 4'h0); // 160
    // force_close during OPENING coinciding with a tick.
    add(4'h1, 4'h0, 1, 1'b0, 16'h0000, 4'h0, 4'h1); // 161
    add(4'h0, 4'h0, 3, 1'b0, 16'h0001, 4'h0, 4'h1); // 164
    add(4'h0, 4'h0, 3, 1'b0, 16'h0001, 4'h0, 4'h1); // 167
    add(4'h0, 4'h1, 1, 1'b0, 16'h0001, 4'h0, 4'h1); // 168
    add(4'h0, 4'h0, 4, 1'b0, 16'h0000, 4'h0, 4'h0); // 172
    // Reset mid-OPENING with the divider off zero, then tick phase restarts.
    add(4'h1, 4'h0, 1, 1'b0, 16'h0000, 4'h0, 4'h1); // 173
    add(4'h0, 4'h0, 3, 1'b0, 16'h0001, 4'h0, 4'h1); // 176
    add(4'h0, 4'h0, 1, 1'b0, 16'h0001, 4'h0, 4'h1); // 177
    add(4'h0, 4'h0, 0, 1'b1, 16'h0000, 4'h0, 4'h0);
    add(4'h1, 4'h0, 1, 1'b0, 16'h0000, 4'h0, 4'h1); // 1
    add(4'h0, 4'h0, 2, 1'b0, 16'h0000, 4'h0, 4'h1); // 3
    add(4'h0, 4'h0, 1, 1'b0, 16'h0001, 4'h0, 4'h1); // 4

    // Power-on reset state, checked while reset is still held.
    #12;
    e0.idx = -1; e0.h = 16'h0000; e0.gopen = 4'h0; e0.gbusy = 4'h0;
    sb.push_back(e0);
    check_outputs(sb.pop_front());
    @(negedge basys_clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/map_gap_controller.md
Name: map_gap_controller

Overview:
- Sequences the four doorway gaps of the yellow cross-shaped arena map: left, right, top and bottom.
- Each gap opens on request, holds open for a programmable time, then closes again, animating 1 px per step tick.
- Outputs the live gap edge coordinates, which the map renderer consumes in place of fixed gap parameters.
- Sits between game logic (open/close requests) and the pixel renderer; one instance per map.

Parameters:
- STEP_DIV, 2500000, basys_clk cycles per animation step tick (40 Hz at 100 MHz); must be >=2.
- HOLD_TICKS, 80, step ticks a gap stays fully open.
- MAX_HALF, 6, maximum gap half-width in px (1..15).
- LEFT_C, 24, x centre of left gap (gap lies on horizontal line).
- RIGHT_C, 72, x centre of right gap.
- TOP_C, 16, y centre of top gap (gap lies on vertical line).
- BOT_C, 48, y centre of bottom gap.
- Constraint: each centre >= MAX_HALF and centre+MAX_HALF <= 95 (x) / 63 (y); violation is a configuration error, not handled in RTL.

Ports:
- basys_clk, in, 1, 100 MHz system clock, all logic on posedge.
- reset, in, 1, asynchronous active-high reset.
- open_req, in, 4, per-gap open request pulse; bit0=left, 1=right, 2=top, 3=bottom.
- force_close, in, 4, per-gap close request (level or pulse).
- left_lo / left_hi, out, 7 each, left gap edges (x).
- right_lo / right_hi, out, 7 each, right gap edges (x).
- top_lo / top_hi, out, 7 each, top gap edges (y).
- bot_lo / bot_hi, out, 7 each, bottom gap edges (y).
- gap_open, out, 4, gap in OPEN state.
- gap_busy, out, 4, gap not in CLOSED state.

Behaviour:
- Tick generator: a shared counter runs 0..STEP_DIV-1 and wraps; tick=1 for exactly one cycle when the counter is STEP_DIV-1. The counter is free-running and is not restarted by requests.
- Per gap: half-width h (4 bit), hold counter (7 bit), and FSM with states CLOSED, OPENING, OPEN, CLOSING.
- Edge outputs are registered: lo=C-h, hi=C+h. h=0 gives lo=hi=C, meaning the line is fully drawn under the renderer rule "draw where coord<=lo or coord>=hi".
- Reset (async): all FSMs CLOSED, h=0, hold=0, tick counter=0. Edge outputs are at their centres (left_lo=left_hi=LEFT_C, and so on). gap_open=0, gap_busy=0.
- CLOSED: open_req bit seen at an edge -> OPENING at that edge. No h change until the next tick.
- OPENING: on tick, h+=1. If the new h==MAX_HALF -> OPEN with hold=0 in the same edge. open_req is ignored.
- OPEN: on tick, hold+=1. A tick with hold==HOLD_TICKS-1 -> CLOSING. open_req -> hold=0, stay OPEN (extend). If open_req and a tick arrive together, the restart wins (hold=0).
- CLOSING: on tick, h-=1. If the new h==0 -> CLOSED. open_req -> OPENING from the current h, with no h change that cycle even if a tick is present.
- force_close bit, in any state except CLOSED: -> CLOSING at that edge, keeping the current h.
  - It overrides open_req in the same cycle.
  - While force_close is held, OPENING/OPEN are not re-entered.
  - A tick in the same cycle does not change h; the decrement starts on the next tick.
- force_close in CLOSED: no effect.
- The four gaps are fully independent; simultaneous requests on all bits are legal.
- Outputs change only on the basys_clk edge where the state or h changes; there is no combinational path from inputs to outputs.
- gap_open/gap_busy are registered and consistent with state in the same cycle as the edge outputs.
- Reset asserted mid-animation: immediate return to reset values. Deassertion resumes with the tick counter at 0.

Test Plan:
- Reset: STEP_DIV=4, MAX_HALF=3, HOLD_TICKS=2, LEFT_C=24 -> all outputs at centres, gap_open=0, gap_busy=0; assert reset mid-OPENING -> immediate return to the same values.
- Open left gap: open_req=0001 pulse -> gap_busy[0]=1 next edge. left_lo/hi go 23/25, 22/26, 21/27 on 3 successive ticks; gap_open[0]=1 at the third tick.
- Hold and close, same config: gap_open[0] drops 2 ticks after reaching OPEN. Then h steps 2,1,0, back to 24/24, and gap_busy[0]=0 on the third closing tick.
- Extend: open_req pulse at hold=1 -> OPEN lasts 2 further ticks from the pulse. Reopen: open_req during CLOSING at h=2 -> OPENING, reaching h=3 on the next tick.
- Conflict: open_req=1111 and force_close=0001 asserted in the same cycle after all gaps are OPEN -> gap 0 enters CLOSING, gaps 1-3 restart hold; force_close in CLOSED leaves all outputs unchanged.
- Independence: staggered open_req on top and bottom 1 tick apart, using TOP_C=16 and BOT_C=48 -> top edges reach 13/19 and bottom edges reach 45/51 one tick apart, with no cross-coupling.
